// File: rtl/alu_result_collector_pkg.sv
// Shared ALU definitions: widths, unit count and the opcode encoding used by
// both the operand-side decoder and the result collector.
package alu_result_collector_pkg;

  localparam int ALU_WIDTH     = 32;
  localparam int ALU_NUM_UNITS = 16;
  localparam int OPCODE_W      = 5;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD  = 5'd0,
    OP_ADC  = 5'd1,
    OP_SUB  = 5'd2,
    OP_SBB  = 5'd3,
    OP_MUL  = 5'd4,
    OP_FADD = 5'd5,
    OP_FSUB = 5'd6,
    OP_FMUL = 5'd7,
    OP_AND  = 5'd8,
    OP_OR   = 5'd9,
    OP_XOR  = 5'd10,
    OP_NAND = 5'd11,
    OP_NOR  = 5'd12,
    OP_XNOR = 5'd13,
    OP_NOT  = 5'd14,
    OP_NEG  = 5'd15
  } alu_op_e;

  // Unit i is the producer of opcode i, so the tag is the index zero-extended.
  function automatic logic [OPCODE_W-1:0] unit_to_opcode(input int unit_idx);
    return OPCODE_W'(unit_idx);
  endfunction

endpackage

// File: rtl/alu_result_collector_if.sv
// Result-side and writeback-side bundle of the ALU result collector.
interface alu_result_collector_if #(
  parameter int WIDTH     = alu_result_collector_pkg::ALU_WIDTH,
  parameter int NUM_UNITS = alu_result_collector_pkg::ALU_NUM_UNITS,
  parameter int DEPTH     = 4
);
  import alu_result_collector_pkg::*;

  // Handshake: a transfer happens in a cycle where valid & ready are both
  // high at the rising edge. A producer that raised valid keeps valid and
  // data stable until it sees ready; ready may depend on valid, never the
  // other way round.
  logic [NUM_UNITS-1:0]       res_valid;
  logic [NUM_UNITS*WIDTH-1:0] res_data;
  logic [NUM_UNITS-1:0]       res_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic [OPCODE_W-1:0]        out_opcode;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    input  res_valid, res_data, out_ready,
    output res_ready, out_valid, out_data, out_opcode, count
  );

  modport slave (
    output res_valid, res_data, out_ready,
    input  res_ready, out_valid, out_data, out_opcode, count
  );

endinterface

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after rr_ptr,
// wrapping modulo NUM_UNITS, wins. The pointer itself is owned by the caller.
module alu_rr_arbiter #(
  parameter int NUM_UNITS = 16,
  parameter int IW        = $clog2(NUM_UNITS)
) (
  input  logic [NUM_UNITS-1:0] req,
  input  logic [IW-1:0]        rr_ptr,
  input  logic                 en,
  output logic [NUM_UNITS-1:0] gnt,
  output logic [IW-1:0]        idx,
  output logic                 any
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_UNITS) s = s - NUM_UNITS;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest request is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (en && req[wrap_add(rr_ptr, k)]) begin
        idx = wrap_add(rr_ptr, k);
        any = 1'b1;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_result_collector.sv
// Collects results from the ALU functional units, arbitrates round-robin,
// tags each result with its opcode and queues it for writeback.
module alu_result_collector
  import alu_result_collector_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int NUM_UNITS = ALU_NUM_UNITS,
  parameter int DEPTH     = 4
) (
  input logic                   clk,
  input logic                   rst,
  alu_result_collector_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NUM_UNITS);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0]        count_q;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        rr_next;
  logic [IW-1:0]        win_idx;
  logic [NUM_UNITS-1:0] gnt;
  logic                 any_gnt;
  logic                 push;
  logic                 pop;
  logic                 space;
  logic                 arb_en;
  logic                 not_empty;
  logic [WIDTH-1:0]     win_data;

  logic [WIDTH-1:0]     data_mem [DEPTH];
  logic [OPCODE_W-1:0]  tag_mem  [DEPTH];

  assign not_empty = (count_q != '0);
  assign pop       = not_empty & bus.out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign space     = (count_q < FULL) | pop;
  assign arb_en    = space & ~rst;

  alu_rr_arbiter #(
    .NUM_UNITS (NUM_UNITS),
    .IW        (IW)
  ) u_arb (
    .req    (bus.res_valid),
    .rr_ptr (rr_ptr),
    .en     (arb_en),
    .gnt    (gnt),
    .idx    (win_idx),
    .any    (any_gnt)
  );

  assign push     = any_gnt;
  assign win_data = bus.res_data[int'(win_idx)*WIDTH +: WIDTH];
  assign rr_next  = (int'(win_idx) == NUM_UNITS - 1) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rr_ptr  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        rr_ptr <= rr_next;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries beyond count are never shown at the head.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= win_data;
      tag_mem[wr_ptr]  <= unit_to_opcode(int'(win_idx));
    end
  end

  assign bus.res_ready  = gnt;
  assign bus.out_valid  = not_empty;
  assign bus.out_data   = not_empty ? data_mem[rd_ptr] : '0;
  assign bus.out_opcode = not_empty ? tag_mem[rd_ptr] : '0;
  assign bus.count      = count_q;

  grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.res_ready));
  count_bound_a:  assert property (@(posedge clk) disable iff (rst) count_q <= FULL);

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: reset, single push, round-robin,
// fill/stall, drain and asynchronous reset mid-operation.
module tb_alu_result_collector;
  import alu_result_collector_pkg::*;

  localparam int W  = 32;
  localparam int NU = 16;
  localparam int D  = 4;
  localparam int EW = W + 5;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;

  alu_result_collector_if #(.WIDTH(W), .NUM_UNITS(NU), .DEPTH(D)) bus ();

  alu_result_collector #(.WIDTH(W), .NUM_UNITS(NU), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.res_valid = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_unit(input int u, input logic [W-1:0] d);
    bus.res_data[u*W +: W] = d;
    bus.res_valid[u] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.res_valid = 16'hFFFF;
    bus.out_ready = 1'b1;
    step();
    total++; if (bus.res_ready !== 16'h0000) begin bad++; $display("FAIL reset_res_ready: got %h want 0000", bus.res_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    total++; if (bus.out_opcode !== 5'd0) begin bad++; $display("FAIL reset_out_opcode: got %0d want 0", bus.out_opcode); end
    bus.res_valid = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_unit(8, 32'h0F0F0F0F);
    #1;
    total++; if (bus.res_ready !== 16'h0100) begin bad++; $display("FAIL single_grant: got %h want 0100", bus.res_ready); end
    step();
    bus.res_valid = '0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_data !== 32'h0F0F0F0F) begin bad++; $display("FAIL single_out_data: got %h want 0f0f0f0f", bus.out_data); end
    total++; if (bus.out_opcode !== OP_AND) begin bad++; $display("FAIL single_out_opcode: got %0d want 8", bus.out_opcode); end
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", bus.count); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL single_pop_count: got %0d want 0", bus.count); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL single_empty_data: got %h want 0", bus.out_data); end
  endtask

  // rr_ptr is 9 here; units 0 and 4 must alternate with one pop per push.
  task automatic test_round_robin();
    int u;
    set_unit(0, 32'h000000A0);
    set_unit(4, 32'h000000A4);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      u = (k % 2 == 0) ? 0 : 4;
      #1;
      total++; if (bus.res_ready !== 16'(1 << u)) begin bad++; $display("FAIL rr_grant_%0d: got %h want %h", k, bus.res_ready, 16'(1 << u)); end
      step();
      total++; if (bus.out_opcode !== 5'(u)) begin bad++; $display("FAIL rr_opcode_%0d: got %0d want %0d", k, bus.out_opcode, u); end
      total++; if (bus.out_data !== (32'hA0 + 32'(u))) begin bad++; $display("FAIL rr_data_%0d: got %h want %h", k, bus.out_data, 32'hA0 + 32'(u)); end
      total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL rr_count_%0d: got %0d want 1", k, bus.count); end
    end
    bus.res_valid = '0;
    step();
    bus.out_ready = 1'b0;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL rr_final_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_fill_stall();
    int order[4] = '{1, 2, 3, 5};
    do_reset();
    for (int i = 0; i < 4; i++) set_unit(order[i], 32'hC0DE0000 + 32'(order[i]));
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (bus.res_ready !== 16'(1 << order[i])) begin bad++; $display("FAIL fill_grant_%0d: got %h want %h", i, bus.res_ready, 16'(1 << order[i])); end
      step();
      exp_q.push_back({5'(order[i]), 32'hC0DE0000 + 32'(order[i])});
      bus.res_valid[order[i]] = 1'b0;
    end
    set_unit(7, 32'hC0DE0007);
    #1;
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL fill_count: got %0d want 4", bus.count); end
    total++; if (bus.res_ready !== 16'h0000) begin bad++; $display("FAIL full_res_ready: got %h want 0000", bus.res_ready); end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.res_ready !== 16'h0080) begin bad++; $display("FAIL full_push_pop_grant: got %h want 0080", bus.res_ready); end
    total++; if (bus.out_opcode !== OP_ADC) begin bad++; $display("FAIL full_head_opcode: got %0d want 1", bus.out_opcode); end
    step();
    bus.res_valid = '0;
    bus.out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({5'd7, 32'hC0DE0007});
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_push_pop_count: got %0d want 4", bus.count); end
  endtask

  task automatic test_drain();
    bus.res_valid = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      total++; if ({bus.out_opcode, bus.out_data} !== exp_e) begin bad++; $display("FAIL drain_head_%0d: got %h want %h", i, {bus.out_opcode, bus.out_data}, exp_e); end
      step();
    end
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL drain_out_data: got %h want 0", bus.out_data); end
    total++; if (bus.out_opcode !== 5'd0) begin bad++; $display("FAIL drain_out_opcode: got %0d want 0", bus.out_opcode); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL drain_count: got %0d want 0", bus.count); end
  endtask

  // rr_ptr is 8 after the drain, so the order is 9, 12, 6.
  task automatic test_async_reset();
    int order[3] = '{9, 12, 6};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_unit(order[i], 32'h5000 + 32'(order[i]));
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.res_ready !== 16'(1 << order[i])) begin bad++; $display("FAIL ar_grant_%0d: got %h want %h", i, bus.res_ready, 16'(1 << order[i])); end
      step();
      bus.res_valid[order[i]] = 1'b0;
    end
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL ar_pre_count: got %0d want 3", bus.count); end
    #2;
    rst = 1'b1;
    bus.res_valid = '0;
    set_unit(15, 32'hF15);
    set_unit(2, 32'hF02);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ar_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL ar_count: got %0d want 0", bus.count); end
    total++; if (bus.res_ready !== 16'h0000) begin bad++; $display("FAIL ar_res_ready: got %h want 0000", bus.res_ready); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL ar_out_data: got %h want 0", bus.out_data); end
    step();
    rst = 1'b0;
    #1;
    total++; if (bus.res_ready !== 16'h0004) begin bad++; $display("FAIL ar_first_grant: got %h want 0004", bus.res_ready); end
    step();
    bus.res_valid[2] = 1'b0;
    total++; if (bus.out_opcode !== OP_SUB) begin bad++; $display("FAIL ar_first_opcode: got %0d want 2", bus.out_opcode); end
    total++; if (bus.out_data !== 32'hF02) begin bad++; $display("FAIL ar_first_data: got %h want 00000f02", bus.out_data); end
    #1;
    total++; if (bus.res_ready !== 16'h8000) begin bad++; $display("FAIL ar_second_grant: got %h want 8000", bus.res_ready); end
    step();
    bus.res_valid = '0;
    total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL ar_second_count: got %0d want 2", bus.count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.res_valid = '0;
    bus.res_data  = '0;
    bus.out_ready = 1'b0;
    step();
    test_reset();
    test_single();
    test_round_robin();
    test_fill_stall();
    test_drain();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
